// File: rtl/l1_seq_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the L1 lookup sequencer: FSM states, default geometry and line alignment.
package l1_seq_pkg;
    localparam int L1_ADDR_W   = 32;
    localparam int L1_LINE_OFF = 7;
    localparam int L1_DELAY_W  = 10;
    localparam int L1_STAT_W   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        CHECK  = 3'd2,
        REQ    = 3'd3,
        WAIT   = 3'd4,
        FILL   = 3'd5,
        DONE   = 3'd6
    } seq_state_e;

    // Clears the low 'off' bits; callers cast the result back to their address width.
    function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned off);
        logic [63:0] mask;
        mask = ~((64'd1 << off) - 64'd1);
        return addr & mask;
    endfunction
endpackage

// File: rtl/l1_seq_delay_cnt.sv
`timescale 1ns/1ps
// Saturating up-counter: loads CLR_VAL on i_clr, counts on i_en, holds while i_stall.
// One-cycle update latency; never wraps past all-ones.
module l1_seq_delay_cnt #(
    parameter int             W       = 10,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_stall,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_stall) begin
            if (i_clr) begin
                r_cnt <= CLR_VAL;
            end else if (i_en && (r_cnt != {W{1'b1}})) begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/l1_lookup_sequencer.sv
`timescale 1ns/1ps
// Drives coalesced segments through L1 tag lookup, miss fill and replay; L1_SEQ_STATS_EN adds hit/miss counters.
// Hit segment: 3 cycles accept-to-ready; segments accepted only in IDLE; stall freezes state, counters and strobes.
module l1_lookup_sequencer
    import l1_seq_pkg::*;
#(
    parameter int ADDR_W   = L1_ADDR_W,
    parameter int LINE_OFF = L1_LINE_OFF,
    parameter int DELAY_W  = L1_DELAY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               seg_valid,
    output logic               seg_ready,
    input  logic [ADDR_W-1:0]  seg_addr,
    input  logic               seg_last,
    output logic               lookup_valid,
    output logic [ADDR_W-1:0]  lookup_addr,
    input  logic               lookup_hit,
    output logic               tag_write,
    output logic [ADDR_W-1:0]  tag_write_addr,
    output logic               fill_req_valid,
    input  logic               fill_req_ready,
    output logic [ADDR_W-1:0]  fill_req_addr,
    input  logic               fill_rsp_valid,
    output logic               done,
`ifdef L1_SEQ_STATS_EN
    output logic [15:0]        hit_cnt,
    output logic [15:0]        miss_cnt,
`endif
    output logic [DELAY_W-1:0] delay
);
    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_last;
    logic               r_first;
    logic [DELAY_W-1:0] r_delay;
    logic [DELAY_W-1:0] w_cnt;
    logic [ADDR_W-1:0]  w_seg_line;
    logic               w_accept;
    logic               w_cnt_clr;
    logic               w_cnt_en;

    assign w_seg_line = ADDR_W'(line_align(64'(seg_addr), LINE_OFF));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Every transition is gated by !stall so a stalled cycle is a true no-op.
    always_comb begin
        w_state_nxt    = r_state;
        seg_ready      = 1'b0;
        lookup_valid   = 1'b0;
        tag_write      = 1'b0;
        fill_req_valid = 1'b0;
        done           = 1'b0;
        w_accept       = 1'b0;
        case (r_state)
            IDLE: begin
                seg_ready = !stall;
                w_accept  = seg_valid && !stall;
                if (w_accept) begin
                    w_state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                lookup_valid = !stall;
                if (!stall) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!stall) begin
                    if (!lookup_hit) begin
                        w_state_nxt = REQ;
                    end else if (r_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            REQ: begin
                fill_req_valid = 1'b1;
                if (fill_req_ready && !stall) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (fill_rsp_valid && !stall) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                tag_write = !stall;
                if (!stall) begin
                    w_state_nxt = LOOKUP;
                end
            end
            DONE: begin
                done = !stall;
                if (!stall) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // r_first marks "no instruction in flight": the next accept restarts the latency count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_last  <= 1'b0;
            r_first <= 1'b1;
            r_delay <= '0;
        end else if (!stall) begin
            if (w_accept) begin
                r_addr  <= w_seg_line;
                r_last  <= seg_last;
                r_first <= 1'b0;
            end else if (r_state == DONE) begin
                r_first <= 1'b1;
            end
            if (r_state == DONE) begin
                r_delay <= w_cnt;
            end
        end
    end

    assign w_cnt_clr = w_accept && r_first;
    assign w_cnt_en  = !r_first;

    l1_seq_delay_cnt #(
        .W       (DELAY_W),
        .CLR_VAL (DELAY_W'(1))
    ) u_delay_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_stall (stall),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_cnt   (w_cnt)
    );

    assign lookup_addr    = r_addr;
    assign tag_write_addr = r_addr;
    assign fill_req_addr  = r_addr;
    // Present the live count alongside the done pulse, then hold it until the next one.
    assign delay          = (r_state == DONE) ? w_cnt : r_delay;

`ifdef L1_SEQ_STATS_EN
    logic r_replay;
    logic w_chk;

    assign w_chk = (r_state == CHECK);

    // A lookup following FILL is a replay; its hit is the installed line, not a real hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_replay <= 1'b0;
        end else if (!stall) begin
            if (r_state == FILL) begin
                r_replay <= 1'b1;
            end else if (r_state == CHECK) begin
                r_replay <= 1'b0;
            end
        end
    end

    l1_seq_delay_cnt #(
        .W       (L1_STAT_W)
    ) u_hit_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_stall (stall),
        .i_clr   (1'b0),
        .i_en    (w_chk && lookup_hit && !r_replay),
        .o_cnt   (hit_cnt)
    );

    l1_seq_delay_cnt #(
        .W       (L1_STAT_W)
    ) u_miss_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_stall (stall),
        .i_clr   (1'b0),
        .i_en    (w_chk && !lookup_hit),
        .o_cnt   (miss_cnt)
    );
`endif
endmodule

// File: tb/tb_l1_lookup_sequencer.sv
`timescale 1ns/1ps
// Randomized bench for l1_lookup_sequencer: expected behaviour is a timeline of active cycles built from the latency rules.
module tb_l1_lookup_sequencer;
    localparam int LOFF  = 7;
    localparam int DMAX  = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        seg_valid = 1'b0;
    logic        seg_ready;
    logic [31:0] seg_addr = '0;
    logic        seg_last = 1'b0;
    logic        lookup_valid;
    logic [31:0] lookup_addr;
    logic        lookup_hit = 1'b0;
    logic        tag_write;
    logic [31:0] tag_write_addr;
    logic        fill_req_valid;
    logic        fill_req_ready = 1'b0;
    logic [31:0] fill_req_addr;
    logic        fill_rsp_valid = 1'b0;
    logic        done;
    logic [9:0]  delay;
`ifdef L1_SEQ_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    l1_lookup_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .seg_valid      (seg_valid),
        .seg_ready      (seg_ready),
        .seg_addr       (seg_addr),
        .seg_last       (seg_last),
        .lookup_valid   (lookup_valid),
        .lookup_addr    (lookup_addr),
        .lookup_hit     (lookup_hit),
        .tag_write      (tag_write),
        .tag_write_addr (tag_write_addr),
        .fill_req_valid (fill_req_valid),
        .fill_req_ready (fill_req_ready),
        .fill_req_addr  (fill_req_addr),
        .fill_rsp_valid (fill_rsp_valid),
        .done           (done),
`ifdef L1_SEQ_STATS_EN
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt),
`endif
        .delay          (delay)
    );

    always #5 clk = ~clk;

    // One entry per non-stalled cycle the DUT is expected to spend.
    typedef struct {
        bit          idle, acc, lk, ck, req, wt, fil, dn;
        bit          hit, rdy, rsp, replay, last;
        logic [31:0] addr, line;
        int          dly, pre;
    } slot_t;

    slot_t       tl[$];
    slot_t       cur_s;
    slot_t       pend;
    bit          pend_v = 1'b0;
    bit          cur_st = 1'b0;
    bit          chk_en = 1'b0;
    int unsigned stall_pct = 0;
    int          exp_hold = 0;
    int          acc_dly = 0;
    bit          first_seg = 1'b1;
    logic [15:0] m_hit = '0;
    logic [15:0] m_miss = '0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done = 0;
    logic [31:0] cap_lk = '0, cap_fr = '0, cap_tw = '0;
    logic [9:0]  cap_dly = '0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic slot_t blank();
        slot_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic add_idle(input int n);
        slot_t s;
        for (int i = 0; i < n; i++) begin
            s = blank();
            s.idle = 1'b1;
            tl.push_back(s);
        end
    endtask

    // Appends one segment: optional gap, accept, (lookup, check[, fill sequence]) per attempt, DONE if last.
    task automatic add_seg(input logic [31:0] a, input bit last, input int gap, input int nmiss,
                           input int ra, input int rw, input int req_stall);
        slot_t       s;
        logic [31:0] ln;
        ln = a & ~((32'd1 << LOFF) - 32'd1);
        if (!first_seg) acc_dly += gap + 1;
        add_idle(gap);
        s = blank(); s.idle = 1'b1; s.acc = 1'b1; s.addr = a; s.last = last;
        tl.push_back(s);
        first_seg = 1'b0;
        for (int m = 0; m <= nmiss; m++) begin
            s = blank(); s.lk = 1'b1; s.line = ln; tl.push_back(s);
            s = blank(); s.ck = 1'b1; s.hit = (m == nmiss); s.replay = (m > 0); tl.push_back(s);
            acc_dly += 2;
            if (m < nmiss) begin
                for (int r = 0; r < ra; r++) begin
                    s = blank(); s.req = 1'b1; s.line = ln; s.rdy = (r == ra - 1);
                    s.pre = (r == 0) ? req_stall : 0;
                    tl.push_back(s);
                end
                for (int w = 0; w < rw; w++) begin
                    s = blank(); s.wt = 1'b1; s.rsp = (w == rw - 1); tl.push_back(s);
                end
                s = blank(); s.fil = 1'b1; s.line = ln; tl.push_back(s);
                acc_dly += ra + rw + 1;
            end
        end
        if (last) begin
            acc_dly += 1;
            s = blank(); s.dn = 1'b1; s.dly = (acc_dly > DMAX) ? DMAX : acc_dly;
            tl.push_back(s);
            acc_dly = 0;
            first_seg = 1'b1;
        end
    endtask

    task automatic step(input slot_t s, input bit st);
        @(posedge clk);
        #1;
        if (pend_v) begin
            if (pend.dn) exp_hold = pend.dly;
            if (pend.ck && pend.hit && !pend.replay && m_hit != 16'hFFFF) m_hit = m_hit + 16'd1;
            if (pend.ck && !pend.hit && m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
            pend_v = 1'b0;
        end
        cur_s  = s;
        cur_st = st;
        chk_en = 1'b1;
        stall      = st;
        seg_valid  = s.idle ? s.acc : 1'($urandom_range(1));
        seg_addr   = s.acc ? s.addr : $urandom;
        seg_last   = s.acc ? s.last : 1'($urandom_range(1));
        lookup_hit = s.ck ? s.hit : 1'($urandom_range(1));
        if (st) begin
            fill_req_ready = s.req ? 1'b1 : 1'($urandom_range(1));
            fill_rsp_valid = s.wt ? 1'b0 : 1'($urandom_range(1));
        end else begin
            fill_req_ready = s.req ? s.rdy : 1'($urandom_range(1));
            fill_rsp_valid = s.wt ? s.rsp : 1'($urandom_range(1));
        end
    endtask

    task automatic run_n(input int n);
        int    k;
        slot_t s;
        k = 0;
        while (tl.size() > 0 && (n < 0 || k < n)) begin
            s = tl.pop_front();
            for (int i = 0; i < s.pre; i++) step(s, 1'b1);
            while ($urandom_range(99) < stall_pct) step(s, 1'b1);
            step(s, 1'b0);
            pend   = s;
            pend_v = 1'b1;
            k++;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("seg_ready", seg_ready, cur_s.idle && !cur_st);
            chk1("lookup_valid", lookup_valid, cur_s.lk && !cur_st);
            chk1("tag_write", tag_write, cur_s.fil && !cur_st);
            chk1("fill_req_valid", fill_req_valid, cur_s.req);
            chk1("done", done, cur_s.dn && !cur_st);
            if (cur_s.lk)  chkw("lookup_addr", 64'(lookup_addr), 64'(cur_s.line));
            if (cur_s.req) chkw("fill_req_addr", 64'(fill_req_addr), 64'(cur_s.line));
            if (cur_s.fil) chkw("tag_write_addr", 64'(tag_write_addr), 64'(cur_s.line));
            chkw("delay", 64'(delay), 64'(cur_s.dn ? cur_s.dly : exp_hold));
`ifdef L1_SEQ_STATS_EN
            chkw("hit_cnt", 64'(hit_cnt), 64'(m_hit));
            chkw("miss_cnt", 64'(miss_cnt), 64'(m_miss));
`endif
        end
        if (lookup_valid)   cap_lk <= lookup_addr;
        if (fill_req_valid) cap_fr <= fill_req_addr;
        if (tag_write)      cap_tw <= tag_write_addr;
        if (done) begin
            cap_dly <= delay;
            n_done  <= n_done + 1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        #20 reset = 1'b1;
        #5;
        chk1("rst_lookup_valid", lookup_valid, 1'b0);
        chk1("rst_fill_req_valid", fill_req_valid, 1'b0);
        chk1("rst_tag_write", tag_write, 1'b0);
        chk1("rst_done", done, 1'b0);
        chkw("rst_delay", 64'(delay), 64'd0);
        #5 reset = 1'b0;
        #3;
        chk1("post_rst_seg_ready", seg_ready, 1'b1);
        chkw("post_rst_lookup_addr", 64'(lookup_addr), 64'd0);
        chk1("post_rst_done", done, 1'b0);

        // Single hit segment.
        add_idle(2);
        add_seg(32'hAAAAAAAA, 1'b1, 0, 0, 1, 1, 0);
        add_idle(2);
        run_n(-1);
        chkw("A_lookup_addr", 64'(cap_lk), 64'hAAAAAA80);
        chkw("A_delay", 64'(cap_dly), 64'd3);

        // Miss: ready on 2nd REQ cycle, response after 5 WAIT cycles.
        add_seg(32'hAAAAABEA, 1'b1, 0, 1, 2, 5, 0);
        add_idle(2);
        run_n(-1);
        chkw("B_fill_req_addr", 64'(cap_fr), 64'hAAAAAB80);
        chkw("B_tag_write_addr", 64'(cap_tw), 64'hAAAAAB80);
        chkw("B_delay", 64'(cap_dly), 64'd13);

        // Two hit segments, one done pulse.
        d0 = n_done;
        add_seg(32'h12345678, 1'b0, 0, 0, 1, 1, 0);
        add_seg(32'h12345900, 1'b1, 0, 0, 1, 1, 0);
        add_idle(2);
        run_n(-1);
        chkw("C_done_pulses", 64'(n_done - d0), 64'd1);
        chkw("C_delay", 64'(cap_dly), 64'd6);

        // Same miss with 4 stalled cycles in REQ.
        add_seg(32'hAAAAABEA, 1'b1, 0, 1, 2, 5, 4);
        add_idle(2);
        run_n(-1);
        chkw("D_stall_delay", 64'(cap_dly), 64'd13);

        // Long fill saturates the latency counter.
        add_seg(32'h0BADF00D, 1'b1, 0, 1, 1, 1100, 0);
        add_idle(2);
        run_n(-1);
        chkw("E_sat_delay", 64'(cap_dly), 64'd1023);

        // Reset while waiting for a fill.
        add_seg(32'h55555555, 1'b1, 0, 1, 1, 20, 0);
        run_n(7);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        stall = 1'b0; seg_valid = 1'b0; fill_rsp_valid = 1'b0; fill_req_ready = 1'b0;
        reset = 1'b1;
        #2;
        chk1("F_rst_fill_req_valid", fill_req_valid, 1'b0);
        chk1("F_rst_tag_write", tag_write, 1'b0);
        chkw("F_rst_delay", 64'(delay), 64'd0);
`ifdef L1_SEQ_STATS_EN
        chkw("F_rst_miss_cnt", 64'(miss_cnt), 64'd0);
`endif
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 fill_rsp_valid = 1'b1;
        @(negedge clk);
        chk1("F_seg_ready", seg_ready, 1'b1);
        chk1("F_no_tag_write", tag_write, 1'b0);
        @(posedge clk);
        #1 fill_rsp_valid = 1'b0;
        @(negedge clk);
        chk1("F_no_tag_write2", tag_write, 1'b0);
        chk1("F_no_fill_req", fill_req_valid, 1'b0);
        tl.delete();
        pend_v = 1'b0; exp_hold = 0; acc_dly = 0; first_seg = 1'b1;
        m_hit = '0; m_miss = '0;

        // Randomized instructions with random stalls and noise on ignored inputs.
        stall_pct = 15;
        for (int n = 0; n < 50; n++) begin
            int nseg;
            nseg = 1 + int'($urandom_range(2));
            for (int k = 0; k < nseg; k++) begin
                int nm;
                nm = int'($urandom_range(3));
                nm = (nm > 0) ? nm - 1 : 0;
                add_seg($urandom, (k == nseg - 1), int'($urandom_range(2)), nm,
                        1 + int'($urandom_range(3)), 1 + int'($urandom_range(7)), 0);
            end
            add_idle(int'($urandom_range(2)));
        end
        add_idle(2);
        run_n(-1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/l1_lookup_sequencer.md
Name: l1_lookup_sequencer

Overview:
- Sequences coalesced memory segments from the coalescer into the L1 tag unit.
- Issues one tag lookup per segment and samples the hit one cycle later.
- On a miss: issues a line fill to lower memory, waits for the fill, writes the tag, then replays the lookup.
- Reports per-instruction latency (`delay`) and a `done` pulse to the LSU pipeline.

Parameters:
- ADDR_W, 32, address width.
- LINE_OFF, 7, log2 of the line size in bytes (128 B lines); low LINE_OFF address bits are zeroed on all outbound addresses.
- DELAY_W, 10, width of the latency counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  pipeline stall; freezes the FSM, counters and all outputs
- seg_valid  in  1  coalesced segment available
- seg_ready  out  1  segment accepted this cycle when seg_valid && seg_ready
- seg_addr  in  ADDR_W  segment byte address
- seg_last  in  1  segment is the last of its warp instruction
- lookup_valid  out  1  tag lookup strobe
- lookup_addr  out  ADDR_W  line-aligned lookup address
- lookup_hit  in  1  tag result, valid exactly 1 cycle after lookup_valid
- tag_write  out  1  one-cycle tag install strobe
- tag_write_addr  out  ADDR_W  line address to install
- fill_req_valid  out  1  fill request to lower memory
- fill_req_ready  in  1  lower memory accepts the request
- fill_req_addr  out  ADDR_W  line address requested
- fill_rsp_valid  in  1  fill data returned (in order, one outstanding)
- done  out  1  one-cycle pulse: instruction complete
- delay  out  DELAY_W  cycles taken by the completed instruction; held until next done

Behaviour:
- Reset values: all outputs 0; state IDLE; latched address 0; counter 0.
- States and transitions:
  - IDLE: seg_ready = !stall. On accept, latch line address and seg_last, go to LOOKUP. If this is the first segment of an instruction, clear the counter to 1.
  - LOOKUP: lookup_valid = 1 for one cycle, lookup_addr = latched address; go to CHECK.
  - CHECK: sample lookup_hit.
    - Hit with last = 1: go to DONE.
    - Hit with last = 0: go to IDLE.
    - Miss: go to REQ.
  - REQ: fill_req_valid = 1 and fill_req_addr held until fill_req_ready; on handshake go to WAIT.
  - WAIT: on fill_rsp_valid go to FILL.
  - FILL: tag_write = 1 for one cycle, tag_write_addr = latched address; go to LOOKUP (replay).
  - DONE: done = 1; delay = counter; go to IDLE.
- Latency:
  - Hit segment: 3 cycles from accept to next seg_ready (IDLE, LOOKUP, CHECK).
  - Miss segment: adds REQ + WAIT + FILL + replay (LOOKUP, CHECK).
- Counter:
  - Increments every non-stalled cycle from first accept through DONE.
  - Saturates at 2^DELAY_W-1, no wrap.
- stall:
  - All state, counter and output registers hold.
  - Strobe outputs (lookup_valid, tag_write, done) are suppressed while stalled and reassert when stall drops.
  - Exception: lookup_hit is still sampled in CHECK only when !stall; the tag unit holds its result under stall.
- Replay miss: a second miss on the same line after FILL re-enters REQ. No lockout.
- fill_rsp_valid outside WAIT is ignored. fill_req_ready outside REQ is ignored.
- seg_valid outside IDLE is not accepted (seg_ready = 0).
- Reset mid-operation: abandons any outstanding fill; returns to IDLE with outputs 0.

Optional Feature:
- Macro L1_SEQ_STATS_EN.
- Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - hit_cnt increments on CHECK with hit, excluding replay hits.
  - miss_cnt increments on CHECK with miss.
  - Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: ports absent; no counter logic.

Decomposition:
- Package l1_seq_pkg: state enum (IDLE, LOOKUP, CHECK, REQ, WAIT, FILL, DONE), LINE_OFF, DELAY_W defaults, line-align mask function.
- Sub-module l1_seq_delay_cnt: saturating, stall-gated, clearable counter.
  - Instantiated once for delay.
  - With L1_SEQ_STATS_EN, instantiated twice more for the stats.

Test Plan:
- Reset at t=20–30 ns, then idle → all outputs 0, seg_ready = 1.
- Single segment 0xAAAAAAAA, seg_last = 1, lookup_hit = 1 → lookup_addr = 0xAAAAAA80, done 3 cycles after accept, delay = 3.
- Segment 0xAAAAABEA, miss, fill_req_ready after 2 cycles, fill_rsp_valid 5 cycles later → fill_req_addr = 0xAAAAAB80, tag_write_addr = 0xAAAAAB80, replay hit, done, delay = 13.
- Two segments (seg_last 0, then 1), both hit → one done pulse only, after the second segment; delay = 6.
- stall held 4 cycles during REQ → fill_req_valid held, no handshake; delay grows by 0 during the stall.
- Reset asserted in WAIT → state IDLE, fill_rsp_valid next cycle produces no tag_write. With L1_SEQ_STATS_EN, miss_cnt = 0 after reset.
